// File: rtl/membank_pingpong_ctrl.sv
// Ping-pong sequencer for two 8x32 banks (sync write, async read) feeding an FFT stage.
// Latency: a frame is readable in the cycle right after its 8th word is accepted; write strobes are same-cycle combinational.
// Backpressure: in_ready = !full[wsel] (drops only when both banks hold frames); out_valid = full[rsel], independent of out_ready.
//
// Ports:
//   clk, reset (async, active-high), flush (sync clear, beats any transfer)
//   in_valid/in_ready/in_data      producer handshake
//   out_valid/out_ready/out_data   consumer handshake, out_last marks word 8 of a frame
//   bank_full[1:0]                 per-bank frame-held flag
//   bankN_write_add/_data/_memwrite_en, bankN_read_add/_read_data   bank N memory port
//
// Build option: define BITREV_READ_EN to drain each frame in 3-bit bit-reversed address order.

module membank_pingpong_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic        out_last,
   input  logic        out_ready,
   output logic [1:0]  bank_full,
   output logic [2:0]  bank0_write_add,
   output logic [31:0] bank0_write_data,
   output logic        bank0_memwrite_en,
   output logic [2:0]  bank0_read_add,
   input  logic [31:0] bank0_read_data,
   output logic [2:0]  bank1_write_add,
   output logic [31:0] bank1_write_data,
   output logic        bank1_memwrite_en,
   output logic [2:0]  bank1_read_add,
   input  logic [31:0] bank1_read_data
);

   logic       wsel;
   logic       rsel;
   logic [2:0] wcnt;
   logic [2:0] rcnt;
   logic [1:0] full;
   logic [1:0] full_nxt;
   logic       wr_fire;
   logic       rd_fire;
   logic [2:0] rd_addr;

   assign in_ready  = !full[wsel];
   assign out_valid = full[rsel];
   assign out_last  = out_valid && (rcnt == 3'd7);
   assign bank_full = full;

   // A flush cycle must not touch the banks, so it also masks the fires.
   assign wr_fire = in_valid && in_ready && !flush;
   assign rd_fire = out_valid && out_ready && !flush;

`ifdef BITREV_READ_EN
   assign rd_addr = {rcnt[0], rcnt[1], rcnt[2]};
`else
   assign rd_addr = rcnt;
`endif

   // Both banks see the same address/data; only the enable selects the bank.
   assign bank0_write_add   = wcnt;
   assign bank1_write_add   = wcnt;
   assign bank0_write_data  = in_data;
   assign bank1_write_data  = in_data;
   assign bank0_memwrite_en = wr_fire && !wsel;
   assign bank1_memwrite_en = wr_fire && wsel;

   assign bank0_read_add = rd_addr;
   assign bank1_read_add = rd_addr;
   assign out_data       = rsel ? bank1_read_data : bank0_read_data;

   // Write needs !full[wsel] and read needs full[rsel], so the set and the
   // clear below never hit the same bank in one cycle.
   always_comb begin
      full_nxt = full;
      if (wr_fire && (wcnt == 3'd7)) begin
         full_nxt[wsel] = 1'b1;
      end
      if (rd_fire && (rcnt == 3'd7)) begin
         full_nxt[rsel] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wsel <= 1'b0;
         rsel <= 1'b0;
         wcnt <= 3'd0;
         rcnt <= 3'd0;
         full <= 2'b00;
      end else if (flush) begin
         wsel <= 1'b0;
         rsel <= 1'b0;
         wcnt <= 3'd0;
         rcnt <= 3'd0;
         full <= 2'b00;
      end else begin
         if (wr_fire) begin
            wcnt <= wcnt + 3'd1;
            if (wcnt == 3'd7) begin
               wsel <= ~wsel;
            end
         end
         if (rd_fire) begin
            rcnt <= rcnt + 3'd1;
            if (rcnt == 3'd7) begin
               rsel <= ~rsel;
            end
         end
         full <= full_nxt;
      end
   end

endmodule

// File: tb/tb_membank_pingpong_ctrl.sv
// Bench for membank_pingpong_ctrl: cycle table for fill/overflow/drain, a
// frame scoreboard for the read stream, and hand sequences for streaming,
// flush and async reset.

module tb_membank_pingpong_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_ready;
   logic [1:0]  bank_full;
   logic [2:0]  bank0_write_add, bank1_write_add;
   logic [31:0] bank0_write_data, bank1_write_data;
   logic        bank0_memwrite_en, bank1_memwrite_en;
   logic [2:0]  bank0_read_add, bank1_read_add;
   logic [31:0] bank0_read_data, bank1_read_data;

   membank_pingpong_ctrl dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready), .bank_full(bank_full),
      .bank0_write_add(bank0_write_add), .bank0_write_data(bank0_write_data),
      .bank0_memwrite_en(bank0_memwrite_en), .bank0_read_add(bank0_read_add),
      .bank0_read_data(bank0_read_data),
      .bank1_write_add(bank1_write_add), .bank1_write_data(bank1_write_data),
      .bank1_memwrite_en(bank1_memwrite_en), .bank1_read_add(bank1_read_add),
      .bank1_read_data(bank1_read_data)
   );

   always #5 clk = ~clk;

   // Bank memories: synchronous write, asynchronous read.
   logic [31:0] mem0 [8];
   logic [31:0] mem1 [8];
   always @(posedge clk) begin
      if (bank0_memwrite_en) mem0[bank0_write_add] <= bank0_write_data;
      if (bank1_memwrite_en) mem1[bank1_write_add] <= bank1_write_data;
   end
   assign bank0_read_data = mem0[bank0_read_add];
   assign bank1_read_data = mem1[bank1_read_add];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [2:0] rmap(input logic [2:0] c);
`ifdef BITREV_READ_EN
      rmap = {c[0], c[1], c[2]};
`else
      rmap = c;
`endif
   endfunction

   // Scoreboard: accepted words are collected per frame and queued in the
   // order the consumer must see them; popped when a read handshake occurs.
   typedef struct { logic [31:0] d; logic last; } exp_t;
   exp_t        sbq[$];
   logic [31:0] wbuf [8];
   int          wn = 0;

   always @(negedge clk) begin
      if (reset || flush) begin
         sbq.delete();
         wn = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected_read", out_data, 32'hxxxxxxxx);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("sb_data", out_data, e.d);
               chk("sb_last", {31'd0, out_last}, {31'd0, e.last});
            end
         end
         if (in_valid && in_ready) begin
            wbuf[wn] = in_data;
            wn++;
            if (wn == 8) begin
               for (int k = 0; k < 8; k++) begin
                  exp_t e;
                  e.d    = wbuf[rmap(3'(k))];
                  e.last = (k == 7);
                  sbq.push_back(e);
               end
               wn = 0;
            end
         end
      end
   end

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        e_ir, e_ov, e_last;
      logic [1:0]  e_bf;
      logic        e_we0, e_we1;
      logic [2:0]  e_wadd, e_radd;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                               input logic ir, input logic ov, input logic lst,
                               input logic [1:0] bf, input logic we0, input logic we1,
                               input logic [2:0] wadd, input logic [2:0] radd);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy; v.e_ir = ir; v.e_ov = ov; v.e_last = lst;
      v.e_bf = bf; v.e_we0 = we0; v.e_we1 = we1; v.e_wadd = wadd; v.e_radd = radd;
      return v;
   endfunction

   vec_t tbl [38];

   task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_v;
      int nv;
      int ir_drops;

      for (int k = 0; k < 8; k++) begin
         mem0[k] = 32'd0;
         mem1[k] = 32'd0;
      end
      for (int i = 0; i < 8; i++)
         tbl[i] = mk(1'b1, 32'h10 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 3'(i), 3'd0);
      for (int i = 8; i < 16; i++)
         tbl[i] = mk(1'b1, 32'h18 + 32'(i - 8), 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 3'(i - 8), 3'd0);
      for (int i = 16; i < 21; i++)
         tbl[i] = mk(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 3'd0, 3'd0);
      for (int i = 21; i < 29; i++)
         tbl[i] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, (i == 28), 2'b11, 1'b0, 1'b0, 3'd0, rmap(3'(i - 21)));
      for (int i = 29; i < 37; i++)
         tbl[i] = mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, (i == 36), 2'b10, 1'b0, 1'b0, 3'd0, rmap(3'(i - 29)));
      tbl[37] = mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0);

      // Reset state
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_last",  {31'd0, out_last},  32'd0);
      chk("rst_bank_full", {30'd0, bank_full}, 32'd0);
      chk("rst_we",        {30'd0, bank1_memwrite_en, bank0_memwrite_en}, 32'd0);
      chk("rst_addrs",     {20'd0, bank0_write_add, bank1_write_add, bank0_read_add, bank1_read_add}, 32'd0);
      reset = 1'b0;

      // Fill both banks, overflow guard, drain
      for (int i = 0; i < 38; i++) begin
         drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0);
         chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].e_ir});
         chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
         chk($sformatf("v%0d_out_last", i),  {31'd0, out_last},  {31'd0, tbl[i].e_last});
         chk($sformatf("v%0d_bank_full", i), {30'd0, bank_full}, {30'd0, tbl[i].e_bf});
         chk($sformatf("v%0d_we", i), {30'd0, bank1_memwrite_en, bank0_memwrite_en},
             {30'd0, tbl[i].e_we1, tbl[i].e_we0});
         chk($sformatf("v%0d_wadd", i), {26'd0, bank1_write_add, bank0_write_add},
             {26'd0, tbl[i].e_wadd, tbl[i].e_wadd});
         chk($sformatf("v%0d_radd", i), {26'd0, bank1_read_add, bank0_read_add},
             {26'd0, tbl[i].e_radd, tbl[i].e_radd});
         if (tbl[i].iv)
            chk($sformatf("v%0d_wdata", i), bank0_write_data ^ bank1_write_data ^ bank0_write_data, tbl[i].d);
         tick();
      end
      chk("fill_sb_empty", 32'(sbq.size()), 32'd0);

      // Streaming 32 words with both sides always ready
      first_v = -1; nv = 0; ir_drops = 0;
      for (int i = 0; i < 40; i++) begin
         drive(i < 32, 32'(i), 1'b1, 1'b0);
         if (i < 32 && !in_ready) ir_drops++;
         if (out_valid) begin
            nv++;
            if (first_v < 0) first_v = i;
         end
         tick();
      end
      chk("stream_in_ready_drops", 32'(ir_drops), 32'd0);
      chk("stream_first_valid",    32'(first_v),  32'd8);
      chk("stream_valid_cycles",   32'(nv),       32'd32);
      chk("stream_bank_full",      {30'd0, bank_full}, 32'd0);
      chk("stream_sb_empty",       32'(sbq.size()), 32'd0);

      // Flush mid-fill
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0);
         chk("pre_flush_we0", {31'd0, bank0_memwrite_en}, 32'd1);
         tick();
      end
      drive(1'b1, 32'hAA, 1'b0, 1'b1);
      chk("flush_we", {30'd0, bank1_memwrite_en, bank0_memwrite_en}, 32'd0);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
         if (i == 0) begin
            chk("post_flush_we", {30'd0, bank1_memwrite_en, bank0_memwrite_en}, 32'd1);
            chk("post_flush_wadd", {29'd0, bank0_write_add}, 32'd0);
            chk("post_flush_out_valid", {31'd0, out_valid}, 32'd0);
         end
         tick();
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      chk("post_flush_frame_valid", {31'd0, out_valid}, 32'd1);
      chk("post_flush_bank_full",   {30'd0, bank_full}, 32'd1);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 32'd0, 1'b1, 1'b0);
         tick();
      end
      chk("flush_drain_bank_full", {30'd0, bank_full}, 32'd0);
      chk("flush_drain_sb_empty",  32'(sbq.size()), 32'd0);

      // Async reset mid-drain
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h60 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'd0, 1'b1, 1'b0);
         tick();
      end
      #2;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("arst_bank_full", {30'd0, bank_full}, 32'd0);
      chk("arst_out_last",  {31'd0, out_last},  32'd0);
      tick();
      reset = 1'b0;
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      chk("arst_after_out_valid", {31'd0, out_valid}, 32'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/membank_pingpong_ctrl.md
# membank_pingpong_ctrl

Ping-pong controller sequencing two 8-word x 32-bit memory banks (asynchronous read, synchronous write) for the 64-point FFT processor. A producer writes 8-sample frames into one bank while a consumer drains the other; banks swap on frame boundaries. Ready/valid handshakes sit on both sides, so an FFT stage can stream at one word per clock without losing or overwriting data.

## Interface
- No parameters: depth fixed at 8 (3-bit address), data width fixed at 32.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all frame state; priority over transfers.
- in_valid  in  1  producer word valid.
- in_data  in  32  producer word.
- in_ready  out  1  controller can accept a word.
- out_valid  out  1  consumer word valid.
- out_data  out  32  consumer word.
- out_last  out  1  current out word is the 8th of its frame.
- out_ready  in  1  consumer accepts the word.
- bank_full  out  2  per-bank full flag.
- bankN_write_add  out  3  write address to bank N (N = 0, 1).
- bankN_write_data  out  32  write data to bank N.
- bankN_memwrite_en  out  1  write enable to bank N.
- bankN_read_add  out  3  read address to bank N.
- bankN_read_data  in  32  asynchronous read data from bank N.

## Operation
- State: wsel (write bank), wcnt[2:0], rsel (read bank), rcnt[2:0], full[1:0]. Each bank cycles EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY. The state is implied by full, wsel/wcnt and rsel/rcnt.
- in_ready = !full[wsel]. It never depends on in_valid.
- Write fires when in_valid && in_ready.
  - bank[wsel]_memwrite_en = 1; the other bank's enable is 0.
  - Both banks see write_add = wcnt and write_data = in_data.
  - wcnt increments. When wcnt == 7: full[wsel] <= 1, wsel toggles, wcnt wraps to 0.
- out_valid = full[rsel]. It never depends on out_ready.
- out_data = bank[rsel]_read_data, read combinationally from the same cycle's read_add.
- Both banks see read_add = map(rcnt).
- Read fires when out_valid && out_ready. rcnt increments. When rcnt == 7: full[rsel] <= 0, rsel toggles, rcnt wraps to 0.
- out_last = out_valid && (rcnt == 7).
- Simultaneous write and read in one cycle: always legal. A write needs !full[wsel] and a read needs full[rsel], so both can never target the same bank.
- Both banks full: in_ready = 0, no write enable asserts, and stored data is never overwritten.
- flush: clears wsel, wcnt, rsel, rcnt and full on the next edge. Any write or read fire in the same cycle is discarded: no counter update and no memwrite_en.
- reset (async): same cleared state, applied immediately.
- Reset values: in_ready = 1, out_valid = 0, out_last = 0, bank_full = 00, both memwrite_en = 0, all addresses = 0. out_data = bank0_read_data (don't care).

## Timing
- memwrite_en, write_add and write_data are combinational from handshake inputs and registered counters. The bank captures on the same edge that the handshake completes.
- Latency: the 8th write accepted at edge E gives out_valid = 1 immediately after E, with data valid in that cycle.
- Throughput: 1 word/clock sustained in and out when both sides are always ready. in_ready never drops in steady streaming.
- After the 16th accept with out_ready = 0, in_ready is 0 from the next cycle.

## Configuration
- BITREV_READ_EN defined: map(rcnt) = {rcnt[0], rcnt[1], rcnt[2]}, a 3-bit bit-reversed drain for FFT reordering.
- BITREV_READ_EN undefined: map(rcnt) = rcnt, natural order.
- out_last is asserted on rcnt == 7 in both cases.

## Test plan
- Fill bank 0: reset, out_ready = 0, write 0x10..0x17. Required: bank_full = 01 and out_valid = 1 after the 8th edge. Writing 0x18..0x1F gives bank_full = 11, then in_ready = 0.
- Drain: from the previous state, set out_ready = 1.
  - Natural order: 0x10..0x17, then 0x18..0x1F, with out_last on the 8th and 16th words.
  - With BITREV_READ_EN: 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17.
  - After drain: bank_full = 00.
- Streaming: in_valid = out_ready = 1 for 32 words 0x0..0x1F. Required: in_ready constant 1, the first out_valid one cycle after the 8th accept, and outputs in sequence at 1 word/clock.
- Overflow guard: with both banks full, hold in_valid = 1 and in_data = 0xDEADBEEF for 5 cycles. Required: both memwrite_en stay 0 and the later drain returns the original data.
- Flush mid-fill: write 3 words, assert flush for one cycle together with in_valid. Required: no write that cycle and out_valid stays 0. The next write goes to bank0 at address 0.
- Async reset mid-drain: assert reset between edges. Required: out_valid = 0, in_ready = 1 and bank_full = 00 immediately, without waiting for a clock edge.
